// File: rtl/spwm_pkg.sv
// spwm_pkg -- shared definitions for the sinusoidal PWM sequencer.
//
// Holds the default staircase geometry (peak step, compare increment,
// duty width, dead time), the step-counter width and the sequencer state
// encoding, so the sequencer and the spwm top level agree on them.
package spwm_pkg;

    localparam int STEPS_DEF     = 21;
    localparam int DUTY_STEP_DEF = 476;
    localparam int W_DEF         = 14;
    localparam int DEAD_CYC_DEF  = 8;

    // Width of the step index; caps the staircase peak at 31.
    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        P_UP    = 3'd1,
        P_DN    = 3'd2,
        DEAD_PN = 3'd3,
        N_UP    = 3'd4,
        N_DN    = 3'd5,
        DEAD_NP = 3'd6
    } spwm_state_t;

    // The positive generator runs only while the positive staircase is live.
    function automatic logic runs_p(input spwm_state_t s);
        return (s == P_UP) || (s == P_DN);
    endfunction

    function automatic logic runs_n(input spwm_state_t s);
        return (s == N_UP) || (s == N_DN);
    endfunction

    // The dead time that follows the negative half still belongs to it.
    function automatic logic is_neg_half(input spwm_state_t s);
        return (s == N_UP) || (s == N_DN) || (s == DEAD_NP);
    endfunction

endpackage

// File: rtl/spwm_seq_dead_timer.sv
// dead_timer -- fixed-length dead-time counter for the SPWM sequencer.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset
//   load   : start a new dead interval (one-cycle pulse)
//   expire : high during the last cycle of the interval, so a state
//            machine acting on it leaves after exactly DEAD_CYC cycles
module dead_timer #(
    parameter int DEAD_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(DEAD_CYC + 1);

    logic [CW-1:0] count;

    // Loaded with the full interval on entry to a dead state, then counts
    // down to zero and parks there until the next load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DEAD_CYC);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    // A value of one marks the final dead cycle: the caller's next edge
    // is the one that leaves the dead state.
    assign expire = (count == CW'(1));

endmodule

// File: rtl/spwm_seq.sv
// spwm_seq -- half-sine staircase sequencer driving a positive/negative
// PWM generator pair.
//
// Each half-cycle steps a compare word up from 0 to STEPS and back down to
// 0, advancing one step per period-end pulse of the active generator, then
// holds both generators idle for DEAD_CYC clocks before the other polarity.
//
// Ports:
//   clk                  : clock, rising edge
//   rst                  : asynchronous active-low reset
//   en                   : run request (level); sampled at start and at
//                          half-cycle boundaries only
//   rdy_p, rdy_n         : period-end pulses from the positive/negative PWM
//   e_p, e_n             : count enables for the positive/negative PWM
//   rst_syn_p, rst_syn_n : synchronous clears holding each PWM idle
//   cnt                  : current step index
//   duty                 : compare word, cnt * DUTY_STEP
//   half                 : polarity, 1 while in the negative half
//   cycle_done           : one-cycle pulse at the end of a full sine period
module spwm_seq
    import spwm_pkg::*;
#(
    parameter int STEPS     = STEPS_DEF,
    parameter int DUTY_STEP = DUTY_STEP_DEF,
    parameter int W         = W_DEF,
    parameter int DEAD_CYC  = DEAD_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rdy_p,
    input  logic             rdy_n,
    output logic             e_p,
    output logic             e_n,
    output logic             rst_syn_p,
    output logic             rst_syn_n,
    output logic [CNT_W-1:0] cnt,
    output logic [W-1:0]     duty,
    output logic             half,
    output logic             cycle_done
);

    // Reject geometries the step counter or the duty word cannot hold.
    if (STEPS < 1 || STEPS > 31) begin : g_bad_steps
        $error("spwm_seq: STEPS must lie in 1..31");
    end
    if (longint'(STEPS) * longint'(DUTY_STEP) > (longint'(1) << W) - 1) begin : g_bad_duty
        $error("spwm_seq: STEPS*DUTY_STEP overflows the W-bit duty word");
    end
    if (DEAD_CYC < 1) begin : g_bad_dead
        $error("spwm_seq: DEAD_CYC must be at least 1");
    end

    localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);
    localparam logic [CNT_W-1:0] PEAK_DN = CNT_W'(STEPS - 1);

    spwm_state_t      state;
    spwm_state_t      state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dead_load;
    logic             dead_expire;
    logic             done_nxt;

    dead_timer #(
        .DEAD_CYC (DEAD_CYC)
    ) u_dead_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (dead_load),
        .expire (dead_expire)
    );

    // Next-state decision. Only the active half's rdy advances the
    // staircase; en is looked at only when a half-cycle or a dead time
    // ends, so a stop request never cuts a staircase short.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dead_load = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = P_UP;
                    cnt_nxt   = '0;
                end
            end
            P_UP: begin
                if (rdy_p) begin
                    if (cnt < STEPS_C) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = P_DN;
                        cnt_nxt   = PEAK_DN;
                    end
                end
            end
            P_DN: begin
                if (rdy_p) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else if (en) begin
                        state_nxt = DEAD_PN;
                        dead_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DEAD_PN: begin
                if (dead_expire) begin
                    state_nxt = en ? N_UP : IDLE;
                    cnt_nxt   = '0;
                end
            end
            N_UP: begin
                if (rdy_n) begin
                    if (cnt < STEPS_C) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end else begin
                        state_nxt = N_DN;
                        cnt_nxt   = PEAK_DN;
                    end
                end
            end
            N_DN: begin
                if (rdy_n) begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end else if (en) begin
                        state_nxt = DEAD_NP;
                        dead_load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DEAD_NP: begin
                if (dead_expire) begin
                    state_nxt = en ? P_UP : IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, step index and every control output are registered together,
    // the outputs being decoded from the state being entered so they line
    // up with it in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            e_p        <= 1'b0;
            e_n        <= 1'b0;
            rst_syn_p  <= 1'b1;
            rst_syn_n  <= 1'b1;
            half       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            e_p        <= runs_p(state_nxt);
            e_n        <= runs_n(state_nxt);
            rst_syn_p  <= !runs_p(state_nxt);
            rst_syn_n  <= !runs_n(state_nxt);
            half       <= is_neg_half(state_nxt);
            cycle_done <= done_nxt;
        end
    end

    // The staircase height never exceeds the duty word, so truncation to W
    // bits is lossless.
    assign duty = W'(32'(cnt) * DUTY_STEP);

endmodule

// File: tb/tb_spwm_seq.sv
// tb_spwm_seq -- self-checking bench for spwm_seq.
//
// A behavioural model tracks where the sequencer must be (idle, position
// within a half-cycle, or remaining dead time) and every output is compared
// against it on each falling clock edge while out of reset. Directed runs
// pin the model with hand-derived figures; a randomized run follows.
module tb_spwm_seq;

    localparam int STEPS     = 21;
    localparam int DUTY_STEP = 476;
    localparam int DEAD_CYC  = 8;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rdy_p;
    logic        rdy_n;
    logic        e_p;
    logic        e_n;
    logic        rst_syn_p;
    logic        rst_syn_n;
    logic [4:0]  cnt;
    logic [13:0] duty;
    logic        half;
    logic        cycle_done;

    int n_compared   = 0;
    int n_mismatched = 0;

    spwm_seq dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rdy_p      (rdy_p),
        .rdy_n      (rdy_n),
        .e_p        (e_p),
        .e_n        (e_n),
        .rst_syn_p  (rst_syn_p),
        .rst_syn_n  (rst_syn_n),
        .cnt        (cnt),
        .duty       (duty),
        .half       (half),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phase 0 = idle, 1 = running a half-cycle,
    // 2 = dead time. m_pol is the polarity of the current or just-finished
    // half, m_k the number of active pulses taken so far in this half
    // (0 .. 2*STEPS), m_dead the dead clocks still to serve.
    int m_phase = 0;
    bit m_pol   = 1'b0;
    int m_k     = 0;
    int m_dead  = 0;
    bit m_done  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_pol   = 1'b0;
            m_k     = 0;
            m_dead  = 0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            case (m_phase)
                0: begin
                    if (en) begin
                        m_phase = 1;
                        m_pol   = 1'b0;
                        m_k     = 0;
                    end
                end
                1: begin
                    if (m_pol ? rdy_n : rdy_p) begin
                        if (m_k < 2 * STEPS) begin
                            m_k++;
                        end else if (en) begin
                            m_phase = 2;
                            m_dead  = DEAD_CYC;
                        end else begin
                            m_phase = 0;
                            m_pol   = 1'b0;
                        end
                    end
                end
                default: begin
                    m_dead--;
                    if (m_dead == 0) begin
                        m_done = m_pol;
                        if (en) begin
                            m_phase = 1;
                            m_pol   = !m_pol;
                            m_k     = 0;
                        end else begin
                            m_phase = 0;
                            m_pol   = 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    function automatic int exp_cnt();
        if (m_phase == 1) return (m_k <= STEPS) ? m_k : 2 * STEPS - m_k;
        return 0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        n_compared++;
        if (actual !== 32'(expected)) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en_v, input bit rdy_p_v, input bit rdy_n_v);
        en    = en_v;
        rdy_p = rdy_p_v;
        rdy_n = rdy_n_v;
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checkOutput("cnt", 32'(cnt), exp_cnt());
            checkOutput("duty", 32'(duty), exp_cnt() * DUTY_STEP);
            checkOutput("e_p", 32'(e_p), int'(m_phase == 1 && !m_pol));
            checkOutput("e_n", 32'(e_n), int'(m_phase == 1 && m_pol));
            checkOutput("rst_syn_p", 32'(rst_syn_p), int'(!(m_phase == 1 && !m_pol)));
            checkOutput("rst_syn_n", 32'(rst_syn_n), int'(!(m_phase == 1 && m_pol)));
            checkOutput("half", 32'(half), int'(m_phase != 0 && m_pol));
            checkOutput("cycle_done", 32'(cycle_done), int'(m_done));
        end
    end

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  pulses, max_cnt, max_duty, dead_cnt, act, done_cnt, first_at, gap_at;
        bit  n_seen, stray_bad, reached, double_done, prev_done, dropped, peak_seen;
        bit  rp, rn;

        // ---- reset and idle values ----
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_cnt", 32'(cnt), 0);
        checkOutput("rst_duty", 32'(duty), 0);
        checkOutput("rst_e", 32'({e_p, e_n}), 0);
        checkOutput("rst_syn", 32'({rst_syn_p, rst_syn_n}), 3);
        checkOutput("rst_half_done", 32'({half, cycle_done}), 0);

        // ---- positive half with rdy_p every 10 clocks ----
        pulses = 0; max_cnt = 0; max_duty = 0; n_seen = 0; reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (e_p) begin
                if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
                if (int'(duty) > max_duty) max_duty = int'(duty);
                if (e_n || !rst_syn_n) n_seen = 1;
            end
            if (pulses > 0 && !e_p) begin
                reached = 1;
                applyStimulus(1, 0, 0);
                break;
            end
            rp = (c % 10 == 9);
            if (rp && e_p) pulses++;
            applyStimulus(1, rp, 0);
        end
        checkOutput("a_half_ended", 32'(reached), 1);
        checkOutput("a_pulses", 32'(pulses), 43);
        checkOutput("a_peak_cnt", 32'(max_cnt), 21);
        checkOutput("a_peak_duty", 32'(max_duty), 9996);
        checkOutput("a_n_quiet", 32'(n_seen), 0);

        // ---- dead time, with stray rdy pulses that must be ignored ----
        dead_cnt = (!e_p && !e_n) ? 1 : 0;
        stray_bad = 0; reached = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (e_n) begin
                reached = 1;
                applyStimulus(1, 0, 0);
                break;
            end
            if (!e_p) dead_cnt++;
            if (cnt != 5'd0 || half) stray_bad = 1;
            applyStimulus(1, 1, bit'(k % 2));
        end
        checkOutput("a_n_started", 32'(reached), 1);
        checkOutput("a_dead_cycles", 32'(dead_cnt), 8);
        checkOutput("a_n_half", 32'(half), 1);
        checkOutput("a_n_cnt0", 32'(cnt), 0);
        checkOutput("a_dead_stray", 32'(stray_bad), 0);

        // ---- full periods: cycle_done spacing, both rdy every 10 clocks ----
        act = 0; done_cnt = 0; first_at = -1; gap_at = -1;
        double_done = 0; prev_done = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (cycle_done) begin
                if (prev_done) double_done = 1;
                done_cnt++;
                if (done_cnt == 1) first_at = act;
                if (done_cnt == 2) gap_at = act - first_at;
            end
            prev_done = cycle_done;
            if (done_cnt == 2) begin
                applyStimulus(1, 0, 0);
                break;
            end
            rp = (c % 10 == 9);
            rn = (c % 10 == 9);
            if ((e_p && rp) || (e_n && rn)) act++;
            applyStimulus(1, rp, rn);
        end
        checkOutput("b_done_count", 32'(done_cnt), 2);
        checkOutput("b_first_done_at", 32'(first_at), 43);
        checkOutput("b_done_gap", 32'(gap_at), 86);
        checkOutput("b_done_width", 32'(double_done), 0);

        // ---- stop request mid staircase ----
        rst = 1'b0;
        applyStimulus(0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        pulses = 0; n_seen = 0; dropped = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (e_n) n_seen = 1;
            if (e_p && cnt == 5'd5 && !dropped) dropped = 1;
            rp = (c % 4 == 3);
            if (rp && e_p) pulses++;
            applyStimulus(!dropped, rp, rp);
        end
        checkOutput("c_dropped", 32'(dropped), 1);
        checkOutput("c_pulses", 32'(pulses), 43);
        checkOutput("c_no_n_half", 32'(n_seen), 0);
        checkOutput("c_idle_e", 32'({e_p, e_n}), 0);
        checkOutput("c_idle_syn", 32'({rst_syn_p, rst_syn_n}), 3);
        checkOutput("c_idle_cnt", 32'(cnt), 0);

        // ---- asynchronous reset in the negative falling staircase ----
        peak_seen = 0; reached = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (e_n && cnt == 5'd21) peak_seen = 1;
            if (peak_seen && e_n && cnt == 5'd12) begin
                reached = 1;
                break;
            end
            rp = (c % 3 == 2);
            applyStimulus(1, rp, rp);
        end
        checkOutput("d_reached_n_dn12", 32'(reached), 1);
        #2 rst = 1'b0;
        #1;
        checkOutput("d_async_cnt", 32'(cnt), 0);
        checkOutput("d_async_e", 32'({e_p, e_n}), 0);
        checkOutput("d_async_syn", 32'({rst_syn_p, rst_syn_n}), 3);
        checkOutput("d_async_half", 32'(half), 0);
        applyStimulus(1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        reached = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (e_p) begin
                reached = 1;
                checkOutput("d_restart_cnt", 32'(cnt), 0);
                checkOutput("d_restart_half", 32'(half), 0);
                break;
            end
        end
        checkOutput("d_restarted", 32'(reached), 1);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            applyStimulus($urandom_range(0, 99) < 90,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/spwm_seq.md
SPWM_SEQ -- requirements
Module: spwm_seq

Interface
REQ-001 The block SHALL have parameter STEPS, default 21, giving the peak step index of one half-sine staircase.
REQ-002 The block SHALL have parameter DUTY_STEP, default 476, giving the compare increment per step.
REQ-003 The block SHALL have parameter W, default 14, giving the duty-word width.
REQ-004 The block SHALL have parameter DEAD_CYC, default 8, giving the dead-time clock cycles between half-cycles.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  run request; level-sensitive.
REQ-008 rdy_p  input  1  one-cycle period-end pulse from the positive PWM generator.
REQ-009 rdy_n  input  1  one-cycle period-end pulse from the negative PWM generator.
REQ-010 e_p, e_n  output  1 each  count enables for the positive/negative generators.
REQ-011 rst_syn_p, rst_syn_n  output  1 each  synchronous clears that hold each generator idle.
REQ-012 cnt  output  5  current step index.
REQ-013 duty  output  W  compare word, equal to cnt*DUTY_STEP.
REQ-014 half  output  1  polarity: 0 = positive, 1 = negative.
REQ-015 cycle_done  output  1  one-cycle pulse at the end of each full sine period.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, P_UP, P_DN, DEAD_PN, N_UP, N_DN, DEAD_NP.
REQ-017 IDLE SHALL go to P_UP on the first clock with en=1, with cnt=0.
REQ-018 In P_UP/N_UP, an active-half rdy SHALL do the following:
- cnt<STEPS: cnt+1.
- cnt==STEPS: enter the matching _DN state with cnt=STEPS-1.
REQ-019 In P_DN/N_DN, an active-half rdy SHALL do the following:
- cnt>0: cnt-1.
- cnt==0: enter DEAD_PN/DEAD_NP, or IDLE if en=0 on that cycle.
REQ-020 Each half-cycle SHALL therefore span 2*STEPS+1 PWM periods (default 43): cnt sequence 0..21 then 20..0.
REQ-021 The dead states SHALL run an internal counter for exactly DEAD_CYC clocks, then go to N_UP (from DEAD_PN) or P_UP (from DEAD_NP), with cnt=0.
REQ-022 A dead state SHALL go to IDLE instead if en=0 when the dead time expires.
REQ-023 cycle_done SHALL pulse in the cycle DEAD_NP exits.
REQ-024 Only the active half's rdy SHALL be honoured: rdy_p in P_*, rdy_n in N_*; rdy in any other state is ignored.
REQ-025 The enables SHALL be:
- e_p=1, rst_syn_p=0 only in P_UP/P_DN.
- e_n=1, rst_syn_n=0 only in N_UP/N_DN.
- Otherwise e=0, rst_syn=1.
REQ-026 half SHALL be 1 in N_UP, N_DN and DEAD_NP, and 0 elsewhere.
REQ-027 All outputs SHALL be registered, except duty, which is combinational from cnt.
REQ-028 cnt and the state SHALL update in the cycle after the rdy pulse (1-clock latency).
REQ-029 en falling mid-half-cycle SHALL NOT truncate the staircase; the block stops only at a half-cycle boundary.
REQ-030 duty SHALL NOT overflow: STEPS*DUTY_STEP <= 2^W-1 (default 9996 < 16384).
REQ-031 Elaboration SHALL fail if REQ-030 is violated or if STEPS > 31.

Reset
REQ-032 rst=0 SHALL asynchronously force all of the following:
- state=IDLE, cnt=0, dead counter=0.
- e_p=e_n=0, rst_syn_p=rst_syn_n=1.
- half=0, cycle_done=0.
REQ-033 Reset asserted mid-operation SHALL abort immediately, with no completion of the half-cycle.
REQ-034 Leaving reset SHALL require en=1 to start, and SHALL always start at P_UP, cnt=0.

Structure
REQ-035 State encoding and default STEPS/DUTY_STEP/W/DEAD_CYC SHALL live in a shared package spwm_pkg, also used by the top level.
REQ-036 The dead-time counter SHALL be a separate sub-module dead_timer (load, expire pulse).
REQ-037 The block SHALL directly drive the existing up/down counter and PWM-generator pair in the spwm top level, replacing its inline fsm.

Verification
REQ-038 Start: reset, then en=1, rdy_p every 10 clocks -> the following:
- cnt 0..21..0 over 43 pulses.
- duty peaks at 9996.
- e_p high throughout; e_n low, rst_syn_n high.
REQ-039 Dead time: after the P_DN cnt=0 rdy_p -> both e low for exactly 8 clocks, then N_UP, half=1, cnt=0.
REQ-040 Full period: run 2 full sine periods -> cycle_done pulses exactly twice, one clock each, 86 active-half pulses apart.
REQ-041 Stray rdy: drive rdy_n during P_UP and rdy_p during DEAD_PN -> cnt and state unchanged.
REQ-042 Stop: drop en at P_UP cnt=5 -> staircase completes to P_DN cnt=0, then IDLE with rst_syn_p=rst_syn_n=1, and no N half.
REQ-043 Mid-operation reset: assert rst=0 at N_DN cnt=12, asynchronous to clk -> outputs reach reset values without waiting for a clk edge; restart begins at P_UP cnt=0.
